// File: rtl/tmds_channel_encoder_pkg.sv
// Shared TMDS definitions: control tokens, disparity type and stage-1 register layout.
// Imported by the channel encoder and anything that needs to recognise control symbols.
package tmds_channel_encoder_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    localparam int unsigned TMDS_DISP_W = 5;

    typedef logic signed [TMDS_DISP_W-1:0] disp_t;

    // Which of the three DC-balance rules applies to the symbol in stage 2
    typedef enum logic [1:0] {
        BAL_NEUTRAL,
        BAL_INVERT,
        BAL_KEEP
    } bal_mode_e;

    typedef struct packed {
        logic [8:0] q_m;
        logic       blank;
        logic [1:0] c;
    } stage1_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            default: tok = TMDS_CTRL_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_popcount8.sv
// Combinational ones counter for an 8-bit vector (result 0..8).
module tmds_popcount8 (
    input  logic [7:0] in_bits,
    output logic [3:0] ones
);

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + {3'b000, in_bits[i]};
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One-channel DVI TMDS 8b/10b encoder: stage 1 minimises transitions,
// stage 2 applies running-disparity DC balance or emits a control token.
module tmds_channel_encoder
    import tmds_channel_encoder_pkg::*;
#(
    parameter logic [9:0] RESET_TOKEN = 10'b1101010100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_blank,
    input  logic [1:0] in_c,
    input  logic [7:0] in_data,
    output logic [9:0] out_tmds
);

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1_in;
    logic       use_xnor;
    logic [8:0] q_m;
    stage1_t    s1_d, s1_q;

    tmds_popcount8 u_pop_in (
        .in_bits (in_data),
        .ones    (n1_in)
    );

    always_comb begin
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !in_data[0]);
        q_m      = '0;
        q_m[0]   = in_data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ in_data[i]) : (q_m[i-1] ^ in_data[i]);
        end
        q_m[8]     = ~use_xnor;
        s1_d.q_m   = q_m;
        s1_d.blank = in_blank;
        s1_d.c     = in_c;
    end

    // ---------------- stage 2: DC balance ----------------
    logic [3:0] n1_qm;
    disp_t      diff;
    disp_t      bias;
    disp_t      cnt_d, cnt_q;
    bal_mode_e  mode;
    logic [9:0] out_d, out_q;

    tmds_popcount8 u_pop_qm (
        .in_bits (s1_q.q_m[7:0]),
        .ones    (n1_qm)
    );

    always_comb begin
        // diff = N1 - N0 = 2*N1 - 8, always within -8..+8
        diff = disp_t'({n1_qm, 1'b0} - 5'd8);
        bias = s1_q.q_m[8] ? 5'sd2 : 5'sd0;

        if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            mode = BAL_NEUTRAL;
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            mode = BAL_INVERT;
        end else begin
            mode = BAL_KEEP;
        end

        out_d = '0;
        cnt_d = cnt_q;
        if (s1_q.blank) begin
            out_d = ctrl_token(s1_q.c);
            cnt_d = '0;
        end else begin
            case (mode)
                BAL_NEUTRAL: begin
                    out_d = {~s1_q.q_m[8], s1_q.q_m[8],
                             s1_q.q_m[8] ? s1_q.q_m[7:0] : ~s1_q.q_m[7:0]};
                    cnt_d = s1_q.q_m[8] ? (cnt_q + diff) : (cnt_q - diff);
                end
                BAL_INVERT: begin
                    out_d = {1'b1, s1_q.q_m[8], ~s1_q.q_m[7:0]};
                    cnt_d = cnt_q + bias - diff;
                end
                default: begin
                    // -2*(~q_m8) folds into bias-2
                    out_d = {1'b0, s1_q.q_m[8], s1_q.q_m[7:0]};
                    cnt_d = cnt_q + bias - 5'sd2 + diff;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q.q_m   <= '0;
            s1_q.blank <= 1'b1;
            s1_q.c     <= 2'b00;
            out_q      <= RESET_TOKEN;
            cnt_q      <= '0;
        end else begin
            s1_q  <= s1_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_tmds = out_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed and line-structured random checks of the TMDS channel encoder
// against hand-computed symbols and an integer DVI reference model.
module tb_tmds_channel_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_blank = 1'b1;
    logic [1:0] in_c = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic [9:0] out_tmds;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    logic [9:0] exp_sym [2];
    bit         exp_v   [2];
    bit         exp_bl  [2];
    logic [7:0] exp_dat [2];
    string      exp_tag [2];

    tmds_channel_encoder #(.RESET_TOKEN(10'b1101010100)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_blank (in_blank),
        .in_c     (in_c),
        .in_data  (in_data),
        .out_tmds (out_tmds)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference encoder; updates m_cnt as a side effect
    function automatic logic [9:0] model_enc(input bit blank, input logic [1:0] c,
                                             input logic [7:0] d);
        int n1d, n1, n0;
        bit xn;
        logic [8:0] qm;
        logic [9:0] o;
        if (blank) begin
            m_cnt = 0;
            case (c)
                2'b00:   o = 10'h354;
                2'b01:   o = 10'h0AB;
                2'b10:   o = 10'h154;
                default: o = 10'h2AB;
            endcase
            return o;
        end
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            if (qm[8]) begin o = {2'b01, qm[7:0]};  m_cnt = m_cnt + n1 - n0; end
            else       begin o = {2'b10, ~qm[7:0]}; m_cnt = m_cnt + n0 - n1; end
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            m_cnt = m_cnt + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            m_cnt = m_cnt - (qm[8] ? 0 : 2) + n1 - n0;
        end
        return o;
    endfunction

    // Applies one input at a negedge; checks the symbol that entered two cycles ago
    task automatic drive(input bit blank, input logic [1:0] c, input logic [7:0] d,
                         input logic [9:0] exp, input bit chk, input string tag);
        logic [7:0] dd, dec;
        int tr;
        @(negedge clk);
        if (exp_v[1]) begin
            checks++;
            if (out_tmds !== exp_sym[1]) begin
                errors++;
                $display("FAIL %s: out_tmds=%h expected %h", exp_tag[1], out_tmds, exp_sym[1]);
            end
            if (!exp_bl[1]) begin
                dd = out_tmds[9] ? ~out_tmds[7:0] : out_tmds[7:0];
                dec[0] = dd[0];
                for (int i = 1; i < 8; i++)
                    dec[i] = out_tmds[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
                checks++;
                if (dec !== exp_dat[1]) begin
                    errors++;
                    $display("FAIL %s_decode: decoded=%h expected %h", exp_tag[1], dec, exp_dat[1]);
                end
                tr = 0;
                for (int i = 1; i < 8; i++) if (out_tmds[i] != out_tmds[i-1]) tr++;
                checks++;
                if (tr > 5) begin
                    errors++;
                    $display("FAIL %s_transitions: got %0d expected <=5", exp_tag[1], tr);
                end
            end
        end
        exp_sym[1] = exp_sym[0]; exp_v[1] = exp_v[0]; exp_bl[1] = exp_bl[0];
        exp_dat[1] = exp_dat[0]; exp_tag[1] = exp_tag[0];
        exp_sym[0] = exp; exp_v[0] = chk; exp_bl[0] = blank; exp_dat[0] = d; exp_tag[0] = tag;
        in_blank = blank;
        in_c     = c;
        in_data  = d;
    endtask

    task automatic drive_model(input bit blank, input logic [1:0] c, input logic [7:0] d,
                               input string tag);
        logic [9:0] e;
        e = model_enc(blank, c, d);
        drive(blank, c, d, e, 1'b1, tag);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_tmds !== 10'h354) begin
                errors++;
                $display("FAIL reset_hold: out_tmds=%h expected 354", out_tmds);
            end
            in_blank = 1'($urandom); in_c = 2'($urandom); in_data = 8'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; in_blank = 1'b1; in_c = 2'b00; in_data = 8'($urandom);
        m_cnt = 0;
        exp_sym[1] = 10'h354; exp_v[1] = 1; exp_bl[1] = 1; exp_tag[1] = "reset_release0";
        exp_sym[0] = 10'h354; exp_v[0] = 1; exp_bl[0] = 1; exp_tag[0] = "reset_release1";
        for (int i = 0; i < 3; i++) drive_model(1'b1, 2'b00, 8'($urandom), "reset_idle");
        checks++;
        if (dut.cnt_q !== 5'sd0) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%0d expected 0", dut.cnt_q);
        end
    endtask

    task automatic test_control;
        drive(1'b1, 2'b00, 8'($urandom), 10'h354, 1'b1, "ctrl00");
        drive(1'b1, 2'b01, 8'($urandom), 10'h0AB, 1'b1, "ctrl01");
        drive(1'b1, 2'b10, 8'($urandom), 10'h154, 1'b1, "ctrl10");
        drive(1'b1, 2'b11, 8'($urandom), 10'h2AB, 1'b1, "ctrl11");
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "ctrl_flush0");
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "ctrl_flush1");
        checks++;
        if (dut.cnt_q !== 5'sd0) begin
            errors++;
            $display("FAIL ctrl_cnt: cnt=%0d expected 0", dut.cnt_q);
        end
        m_cnt = 0;
    endtask

    task automatic test_data_zero;
        drive(1'b1, 2'b10, 8'($urandom), 10'h154, 1'b1, "zero_pre");
        drive(1'b0, 2'($urandom), 8'h00, 10'h100, 1'b1, "zero_first");
        drive(1'b0, 2'($urandom), 8'h00, 10'h3FF, 1'b1, "zero_second");
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "zero_post0");
        checks++;
        if (dut.cnt_q !== -5'sd8) begin
            errors++;
            $display("FAIL zero_cnt1: cnt=%0d expected -8", dut.cnt_q);
        end
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "zero_post1");
        checks++;
        if (dut.cnt_q !== 5'sd2) begin
            errors++;
            $display("FAIL zero_cnt2: cnt=%0d expected 2", dut.cnt_q);
        end
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "zero_post2");
        m_cnt = 0;
    endtask

    task automatic test_data_ff;
        drive(1'b1, 2'b00, 8'($urandom), 10'h354, 1'b1, "ff_pre");
        drive(1'b0, 2'($urandom), 8'hFF, 10'h200, 1'b1, "ff_data");
        drive(1'b1, 2'b01, 8'hFF, 10'h0AB, 1'b1, "ff_post0");
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "ff_post1");
        checks++;
        if (dut.cnt_q !== -5'sd8) begin
            errors++;
            $display("FAIL ff_cnt: cnt=%0d expected -8", dut.cnt_q);
        end
        drive(1'b1, 2'b00, 8'h00, 10'h354, 1'b1, "ff_post2");
        m_cnt = 0;
    endtask

    task automatic test_random_video;
        int cv;
        m_cnt = 0;
        for (int line = 0; line < 6; line++) begin
            for (int i = 0; i < 12; i++) drive_model(1'b1, 2'($urandom), 8'($urandom), "rand_blank");
            for (int px = 0; px < 640; px++) begin
                drive_model(1'b0, 2'($urandom), 8'($urandom), "rand_pixel");
                cv = int'(dut.cnt_q);
                checks++;
                if (cv > 10 || cv < -10) begin
                    errors++;
                    $display("FAIL rand_cnt_bound: cnt=%0d expected |cnt|<=10", cv);
                end
            end
        end
        drive_model(1'b1, 2'b00, 8'h00, "rand_flush0");
        drive_model(1'b1, 2'b00, 8'h00, "rand_flush1");
    endtask

    task automatic test_reset_midline;
        logic [7:0] d;
        logic [1:0] c;
        for (int i = 0; i < 5; i++) drive_model(1'b0, 2'($urandom), 8'($urandom), "mid_pre");
        @(negedge clk);
        reset = 1'b1; in_blank = 1'b0; in_data = 8'($urandom);
        exp_v[0] = 0; exp_v[1] = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_tmds !== 10'h354) begin
                errors++;
                $display("FAIL mid_reset: out_tmds=%h expected 354", out_tmds);
            end
        end
        d = 8'h5A; c = 2'b11;
        m_cnt = 0;
        reset = 1'b0; in_blank = 1'b0; in_c = c; in_data = d;
        exp_sym[1] = 10'h354; exp_v[1] = 1; exp_bl[1] = 1; exp_tag[1] = "mid_release_token";
        exp_sym[0] = model_enc(1'b0, c, d); exp_v[0] = 1; exp_bl[0] = 0;
        exp_dat[0] = d; exp_tag[0] = "mid_first_data";
        for (int i = 0; i < 6; i++) drive_model(1'b0, 2'($urandom), 8'($urandom), "mid_post");
        drive_model(1'b1, 2'b00, 8'h00, "mid_flush0");
        drive_model(1'b1, 2'b00, 8'h00, "mid_flush1");
    endtask

    initial begin
        exp_v[0] = 0; exp_v[1] = 0;
        test_reset;
        test_control;
        test_data_zero;
        test_data_ff;
        test_random_video;
        test_reset_midline;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
